param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, storage words (power of 2, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default 6, almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  WIDTH  write word.
REQ-010 SHALL have port rd_en  input  1  read request (pop).
REQ-011 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-012 SHALL have port rd_data  output  WIDTH  read word.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  words stored.
REQ-014 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL use read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered count of $clog2(DEPTH)+1 bits.
REQ-017 SHALL accept a write iff wr_en=1 and full=1 is false at the clock edge: store wr_data at wr_ptr, then increment wr_ptr.
REQ-018 SHALL accept a read iff rd_en=1 and empty=0 at the clock edge: increment rd_ptr.
REQ-019 SHALL update count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 SHALL evaluate simultaneous rd_en/wr_en against pre-edge flags:
- When full, the read is accepted, the write is rejected, and count becomes DEPTH-1.
- When empty, the write is accepted, the read is rejected, and count becomes 1.
REQ-021 SHALL drive full = (count==DEPTH) and empty = (count==0), decoded from the registered count; flags change in the cycle after the accepting edge.
REQ-022 SHALL drive almost_full = (count>=AF_LEVEL) and almost_empty = (count<=AE_LEVEL).
REQ-023 SHALL, with FWFT=0, register mem[rd_ptr] into rd_data on an accepted read (1-cycle latency); rd_data SHALL hold its value otherwise.
REQ-024 SHALL, with FWFT=1, present mem[rd_ptr] on rd_data whenever empty=0 (0-cycle latency; an accepted read pops the word); rd_data is don't-care while empty=1.
REQ-025 SHALL set overflow on any edge with wr_en=1 and full=1, and underflow on any edge with rd_en=1 and empty=1.
REQ-026 SHALL keep overflow and underflow set until rst=1 or err_clr=1; a new error on the same edge as err_clr SHALL leave the flag set.
REQ-027 SHALL never alter storage contents or pointers on a rejected request.

Reset
REQ-028 SHALL, on rst=1 at an edge, reset wr_ptr=0, rd_ptr=0, count=0, rd_data=0, overflow=0, underflow=0, giving empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 SHALL give rst priority over simultaneous wr_en, rd_en and err_clr; a mid-operation reset discards all stored words.
REQ-030 SHALL not reset storage array contents.

Verification
REQ-031 SHALL cover fill and overflow: reset, then write 0x11..0x88 -> almost_full=1 after the 6th write, full=1 and count=8 after the 8th; a 9th write of 0x99 -> rejected, overflow=1, count=8.
REQ-032 SHALL cover drain and underflow with FWFT=0: 8 reads -> rd_data=0x11..0x88, each one cycle after its rd_en; empty=1 after the 8th; a 9th read -> underflow=1, rd_data holds 0x88.
REQ-033 SHALL cover wrap-around: write 5, read 5, write 0xA0..0xA5, read 6 -> data returned in order across the pointer wrap, count peaks at 6.
REQ-034 SHALL cover simultaneous access:
- Both enables at count=3 -> count stays 3.
- At full -> count=7, overflow=1.
- At empty -> count=1, underflow=1.
REQ-035 SHALL cover FWFT=1: write 0xA5 into an empty FIFO -> next cycle empty=0 and rd_data=0xA5 with no rd_en; rd_en=1 for one cycle -> empty=1.
REQ-036 SHALL cover reset mid-operation: assert rst at count=5 with overflow=1 -> next cycle count=0, empty=1, overflow=0; a following write/read returns the new word only.

Source files
------------

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_fifo
//  Description : Single-clock parameterised FIFO with registered or
//                first-word-fall-through read, level flags and sticky errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int             c_AW    = $clog2(DEPTH);
    localparam int             c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF   = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_AE   = c_CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wr_accept;
    logic             w_rd_accept;

    // Acceptance uses the pre-edge flags, so a full FIFO can still be read
    // and an empty one written on the same edge.
    assign w_wr_accept = wr_en && !full;
    assign w_rd_accept = rd_en && !empty;

    assign count        = r_count;
    assign full         = (r_count == c_FULL);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (!rst && w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            // A fresh error on the clearing edge wins over err_clr.
            r_overflow  <= (r_overflow  && !err_clr) || (wr_en && full);
            r_underflow <= (r_underflow && !err_clr) || (rd_en && empty);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data = r_mem[r_rd_ptr];
    end else begin : g_reg
        logic [WIDTH-1:0] r_rd_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data <= '0;
            end else if (w_rd_accept) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end

        assign rd_data = r_rd_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_fifo
//  Description : Scoreboard bench for param_fifo in registered and FWFT modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    wire  [7:0] rd_data;
    wire  [3:0] count;
    wire        full, empty, almost_full, almost_empty, overflow, underflow;

    logic       wr_en_f = 1'b0, rd_en_f = 1'b0, err_clr_f = 1'b0;
    logic [7:0] wr_data_f = 8'h00;
    wire  [7:0] rd_data_f;
    wire  [3:0] count_f;
    wire        full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    logic [3:0] m_count = 4'd0;
    logic [7:0] m_exp_rd = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always #5 clk = ~clk;

    param_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data), .count(count), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    param_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en_f), .wr_data(wr_data_f), .rd_en(rd_en_f),
        .err_clr(err_clr_f), .rd_data(rd_data_f), .count(count_f), .full(full_f),
        .empty(empty_f), .almost_full(almost_full_f), .almost_empty(almost_empty_f),
        .overflow(overflow_f), .underflow(underflow_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle on the registered FIFO and advances the reference model.
    task automatic do_cycle(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        logic wa, ra;
        wr_en = wr; wr_data = d; rd_en = rd; err_clr = clr;
        wa = wr && (m_count < 4'd8);
        ra = rd && (m_count > 4'd0);
        m_ovf = (m_ovf && !clr) || (wr && (m_count == 4'd8));
        m_unf = (m_unf && !clr) || (rd && (m_count == 4'd0));
        if (ra) m_exp_rd = m_q.pop_front();
        if (wa) m_q.push_back(d);
        if (wa && !ra) m_count = m_count + 4'd1;
        if (ra && !wa) m_count = m_count - 4'd1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_q.delete();
        m_count = 4'd0; m_exp_rd = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin errors++; $display("FAIL reset_flags: got %b want 0101", {full, empty, almost_full, almost_empty}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {overflow, underflow}); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        checks++; if (empty_f !== 1'b1 || count_f !== 4'd0) begin errors++; $display("FAIL reset_fwft: empty %b count %0d want 1/0", empty_f, count_f); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            do_cycle(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
            checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            checks++; if (almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i >= 6)); end
            checks++; if (full !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 8)); end
            checks++; if (almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, (i <= 2)); end
        end
        do_cycle(1'b1, 8'h99, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", overflow); end
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL overflow_count: got %0d full %b want 8/1", count, full); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL overflow_unf: got %b want 0", underflow); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= 8; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_data !== m_exp_rd || rd_data !== 8'(8'h11 * i)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, m_exp_rd); end
            checks++; if (count !== m_count || empty !== (i == 8)) begin errors++; $display("FAIL drain_count[%0d]: got %0d empty %b want %0d/%b", i, count, empty, m_count, (i == 8)); end
        end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL drain_levels: ae %b af %b want 1/0", almost_empty, almost_full); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", underflow); end
        checks++; if (rd_data !== 8'h88) begin errors++; $display("FAIL underflow_hold: got %h want 88", rd_data); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
        // Clear on the same edge as a new underflow: underflow stays, overflow drops.
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if ({overflow, underflow} !== {m_ovf, m_unf} || {overflow, underflow} !== 2'b01) begin errors++; $display("FAIL clr_vs_new: got %b want 01", {overflow, underflow}); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL err_clr: got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_wraparound();
        logic [3:0] peak;
        peak = 4'd0;
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_data !== m_exp_rd) begin errors++; $display("FAIL wrap_pre[%0d]: got %h want %h", i, rd_data, m_exp_rd); end
        end
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
            if (count > peak) peak = count;
        end
        checks++; if (peak !== 4'd6) begin errors++; $display("FAIL wrap_peak: got %0d want 6", peak); end
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_data !== m_exp_rd || rd_data !== 8'(8'hA0 + i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rd_data, m_exp_rd); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 3; i++) do_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        do_cycle(1'b1, 8'hC4, 1'b1, 1'b0);
        checks++; if (count !== 4'd3 || rd_data !== m_exp_rd) begin errors++; $display("FAIL sim_mid: count %0d data %h want 3/%h", count, rd_data, m_exp_rd); end
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        do_cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        checks++; if (count !== 4'd7 || overflow !== 1'b1) begin errors++; $display("FAIL sim_full: count %0d ovf %b want 7/1", count, overflow); end
        checks++; if (rd_data !== m_exp_rd) begin errors++; $display("FAIL sim_full_data: got %h want %h", rd_data, m_exp_rd); end
        for (int i = 0; i < 7; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_data !== m_exp_rd) begin errors++; $display("FAIL sim_drain[%0d]: got %h want %h", i, rd_data, m_exp_rd); end
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        do_cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        checks++; if (count !== 4'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL sim_empty: count %0d unf %b ovf %b want 1/1/0", count, underflow, overflow); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (rd_data !== 8'h3C || rd_data !== m_exp_rd || empty !== 1'b1) begin errors++; $display("FAIL sim_empty_data: got %h empty %b want 3c/1", rd_data, empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) do_cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 4'd5 || overflow !== 1'b1) begin errors++; $display("FAIL mid_pre: count %0d ovf %b want 5/1", count, overflow); end
        wr_en = 1'b1; wr_data = 8'hFF; rd_en = 1'b1; err_clr = 1'b1;
        do_reset();
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL mid_reset: count %0d empty %b ovf %b data %h want 0/1/0/00", count, empty, overflow, rd_data); end
        do_cycle(1'b1, 8'hE7, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rd_data !== 8'hE7 || rd_data !== m_exp_rd || empty !== 1'b1) begin errors++; $display("FAIL mid_new_word: got %h empty %b want e7/1", rd_data, empty); end
    endtask

    task automatic test_fwft();
        logic [7:0] fq[$];
        logic [7:0] exp_f;
        wr_en_f = 1'b1; wr_data_f = 8'hA5; fq.push_back(8'hA5);
        tick();
        wr_en_f = 1'b0;
        exp_f = fq[0];
        checks++; if (empty_f !== 1'b0 || rd_data_f !== exp_f) begin errors++; $display("FAIL fwft_show: empty %b data %h want 0/%h", empty_f, rd_data_f, exp_f); end
        rd_en_f = 1'b1; void'(fq.pop_front());
        tick();
        rd_en_f = 1'b0;
        checks++; if (empty_f !== 1'b1 || count_f !== 4'd0) begin errors++; $display("FAIL fwft_pop: empty %b count %0d want 1/0", empty_f, count_f); end
        for (int i = 0; i < 2; i++) begin
            wr_en_f = 1'b1; wr_data_f = 8'(8'h3B + 8'h11 * i); fq.push_back(wr_data_f);
            tick();
        end
        wr_en_f = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_f = fq.pop_front();
            checks++; if (rd_data_f !== exp_f) begin errors++; $display("FAIL fwft_seq[%0d]: got %h want %h", i, rd_data_f, exp_f); end
            rd_en_f = 1'b1;
            tick();
            rd_en_f = 1'b0;
        end
        checks++; if (empty_f !== 1'b1 || underflow_f !== 1'b0) begin errors++; $display("FAIL fwft_end: empty %b unf %b want 1/0", empty_f, underflow_f); end
    endtask

    initial begin
        tick();
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wraparound();
        test_simultaneous();
        test_reset_mid();
        test_fwft();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
